// File: rtl/fifo_burst_reader.sv
// Read-side consumer for a show-ahead FIFO: pops words in bursts and re-emits
// each burst as a framed stream with a first-beat flag and a trailing XOR checksum beat.
module fifo_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int DATA_DEPTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          fifo_vld_i,
  output logic                          fifo_rdy_o,
  input  logic [DATA_WIDTH-1:0]         fifo_data_i,
  input  logic [$clog2(DATA_DEPTH):0]   fifo_cnt_i,
  input  logic                          flush_i,
  output logic                          out_vld_o,
  input  logic                          out_rdy_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic                          out_sof_o,
  output logic                          out_eof_o,
  output logic                          busy_o,
  output logic [15:0]                   burst_cnt_o
);

  localparam int CW = $clog2(DATA_DEPTH) + 1;
  localparam logic [CW-1:0] BL    = CW'(BURST_LEN);
  localparam logic [31:0]   TO_M1 = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BURST, CSUM} state_t;

  state_t                state;
  logic [CW-1:0]         len;
  logic [CW-1:0]         pcnt;
  logic [DATA_WIDTH-1:0] csum;
  logic [31:0]           wcnt;

  logic can_load;
  logic pop;
  logic full_go;
  logic short_go;
  logic last_pop;
  logic csum_load;

  // Handshake: a word moves from the FIFO on fifo_vld_i & fifo_rdy_o, and a beat
  // leaves on out_vld_o & out_rdy_i. fifo_rdy_o never looks at fifo_vld_i.
  assign can_load   = !out_vld_o || out_rdy_i;
  assign fifo_rdy_o = (state == BURST) && can_load;
  assign pop        = fifo_vld_i && fifo_rdy_o;
  assign last_pop   = pop && (pcnt == len - 1'b1);
  assign csum_load  = (state == CSUM) && can_load;
  assign full_go    = fifo_cnt_i >= BL;
  assign short_go   = (fifo_cnt_i != '0) &&
                      (flush_i || ((TIMEOUT != 0) && (wcnt == TO_M1)));
  assign busy_o     = (state != IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      len         <= '0;
      pcnt        <= '0;
      csum        <= '0;
      wcnt        <= '0;
      out_vld_o   <= 1'b0;
      out_data_o  <= '0;
      out_sof_o   <= 1'b0;
      out_eof_o   <= 1'b0;
      burst_cnt_o <= '0;
    end else begin
      // Single-stage output register; a new load wins over draining.
      if (pop) begin
        out_vld_o  <= 1'b1;
        out_data_o <= fifo_data_i;
        out_sof_o  <= (pcnt == '0);
        out_eof_o  <= 1'b0;
      end else if (csum_load) begin
        out_vld_o  <= 1'b1;
        out_data_o <= csum;
        out_sof_o  <= 1'b0;
        out_eof_o  <= 1'b1;
      end else if (out_vld_o && out_rdy_i) begin
        out_vld_o  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (fifo_cnt_i == '0) wcnt <= '0;
          else                  wcnt <= wcnt + 32'd1;
          if (full_go) begin
            state <= BURST;
            len   <= BL;
            pcnt  <= '0;
            csum  <= '0;
            wcnt  <= '0;
          end else if (short_go) begin
            // Only the words counted now belong to this burst.
            state <= BURST;
            len   <= fifo_cnt_i;
            pcnt  <= '0;
            csum  <= '0;
            wcnt  <= '0;
          end
        end
        BURST: begin
          if (pop) begin
            csum <= csum ^ fifo_data_i;
            pcnt <= pcnt + 1'b1;
            if (last_pop) state <= CSUM;
          end
        end
        CSUM: begin
          if (can_load) begin
            burst_cnt_o <= burst_cnt_o + 16'd1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO model feeds the DUT, directed
// tests push hand-computed beats into exp_q, and a negedge monitor checks them.
module tb_fifo_burst_reader;

  localparam int DW = 32;
  localparam int DD = 8;
  localparam int CW = $clog2(DD) + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          fifo_vld = 1'b0;
  logic          fifo_rdy;
  logic [DW-1:0] fifo_data = '0;
  logic [CW-1:0] fifo_cnt = '0;
  logic          flush = 1'b0;
  logic          out_vld;
  logic          out_rdy = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_sof;
  logic          out_eof;
  logic          busy;
  logic [15:0]   burst_cnt;

  fifo_burst_reader #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .BURST_LEN(4), .TIMEOUT(16)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .fifo_vld_i(fifo_vld), .fifo_rdy_o(fifo_rdy), .fifo_data_i(fifo_data), .fifo_cnt_i(fifo_cnt),
    .flush_i(flush),
    .out_vld_o(out_vld), .out_rdy_i(out_rdy), .out_data_o(out_data),
    .out_sof_o(out_sof), .out_eof_o(out_eof),
    .busy_o(busy), .burst_cnt_o(burst_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [DW+1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic exp_beat(input logic [DW-1:0] d, input logic s, input logic e);
    exp_q.push_back({s, e, d});
  endtask

  // ---------------- FIFO model (show-ahead) ----------------
  logic [DW-1:0] fq[$];
  logic          push_en = 1'b0;
  logic [DW-1:0] push_val = '0;
  logic          pop_now = 1'b0;
  int            cyc = 0;
  int            pop_total = 0;
  int            pop_cyc[$];
  int            last_push_cyc = 0;

  always @(negedge clk) pop_now = fifo_vld && fifo_rdy;

  always @(posedge clk) begin
    cyc++;
    if (pop_now) begin
      void'(fq.pop_front());
      pop_total++;
      pop_cyc.push_back(cyc);
    end
    if (push_en) begin
      fq.push_back(push_val);
      last_push_cyc = cyc;
    end
    fifo_vld  <= (fq.size() != 0);
    fifo_data <= (fq.size() != 0) ? fq[0] : '0;
    fifo_cnt  <= CW'(fq.size());
  end

  // ---------------- monitor ----------------
  logic          prev_stall = 1'b0;
  logic [DW+1:0] prev_beat = '0;
  logic [DW+1:0] cur_beat;
  logic [DW+1:0] exp_b;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      cur_beat = {out_sof, out_eof, out_data};
      if (prev_stall) chk("held_beat", {out_vld, cur_beat}, {1'b1, prev_beat});
      if (out_vld && !out_rdy) chk("fifo_rdy_in_stall", 64'(fifo_rdy), 64'd0);
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat actual=%0h expected=none", cur_beat);
        end else begin
          exp_b = exp_q.pop_front();
          chk("beat {sof,eof,data}", cur_beat, exp_b);
        end
      end
      prev_stall = out_vld && !out_rdy;
      prev_beat  = cur_beat;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [DW-1:0] w);
    push_en  = 1'b1;
    push_val = w;
    @(posedge clk); #1;
    push_en  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !busy && fq.size() == 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, 64'(n < budget), 64'd1);
  endtask

  // ---------------- directed tests ----------------
  int t_push;
  int base;

  initial begin
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst fifo_rdy", 64'(fifo_rdy), 64'd0);
    chk("rst out_vld", 64'(out_vld), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst out_sof", 64'(out_sof), 64'd0);
    chk("rst out_eof", 64'(out_eof), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst burst_cnt", 64'(burst_cnt), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // full burst
    pop_cyc.delete();
    exp_beat(5, 1, 0); exp_beat(6, 0, 0); exp_beat(7, 0, 0); exp_beat(8, 0, 0); exp_beat(12, 0, 1);
    for (int i = 5; i <= 8; i++) push(DW'(i));
    wait_idle("t1 idle", 200);
    chk("t1 pops", 64'(pop_cyc.size()), 64'd4);
    chk("t1 pop span", 64'((pop_cyc.size() >= 4) ? pop_cyc[3] - pop_cyc[0] : -1), 64'd3);
    chk("t1 burst_cnt", 64'(burst_cnt), 64'd1);

    // timeout short burst
    pop_cyc.delete();
    exp_beat(9, 1, 0); exp_beat(10, 0, 0); exp_beat(3, 0, 1);
    push(9);
    t_push = last_push_cyc;
    push(10);
    wait_idle("t2 idle", 200);
    chk("t2 first pop delay", 64'((pop_cyc.size() != 0) ? pop_cyc[0] - t_push : -1), 64'd17);
    chk("t2 burst_cnt", 64'(burst_cnt), 64'd2);

    // backpressure with ready pattern 1,0,0,1
    exp_beat(1, 1, 0); exp_beat(2, 0, 0); exp_beat(3, 0, 0); exp_beat(4, 0, 0); exp_beat(4, 0, 1);
    for (int i = 0; i < 40; i++) begin
      out_rdy  = (i % 4 == 0) || (i % 4 == 3);
      push_en  = (i < 4);
      push_val = DW'(i + 1);
      @(posedge clk); #1;
    end
    push_en = 1'b0;
    out_rdy = 1'b1;
    wait_idle("t3 idle", 200);
    chk("t3 burst_cnt", 64'(burst_cnt), 64'd3);

    // flush of a lone word
    pop_cyc.delete();
    exp_beat(23, 1, 0); exp_beat(23, 0, 1);
    push(23);
    t_push = last_push_cyc;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_idle("t4 idle", 200);
    chk("t4 first pop delay", 64'((pop_cyc.size() != 0) ? pop_cyc[0] - t_push : -1), 64'd2);
    chk("t4 burst_cnt", 64'(burst_cnt), 64'd4);

    // flush with an empty FIFO does nothing
    flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t4 empty flush busy", 64'(busy), 64'd0);
    end
    flush = 1'b0;
    chk("t4 empty flush burst_cnt", 64'(burst_cnt), 64'd4);

    // ten words: two full bursts and a timeout burst
    exp_beat(5, 1, 0); exp_beat(6, 0, 0); exp_beat(7, 0, 0); exp_beat(8, 0, 0); exp_beat(12, 0, 1);
    exp_beat(9, 1, 0); exp_beat(10, 0, 0); exp_beat(11, 0, 0); exp_beat(12, 0, 0); exp_beat(4, 0, 1);
    exp_beat(13, 1, 0); exp_beat(14, 0, 0); exp_beat(3, 0, 1);
    for (int i = 5; i <= 14; i++) push(DW'(i));
    wait_idle("t5 idle", 300);
    chk("t5 burst_cnt", 64'(burst_cnt), 64'd7);

    // reset after the second pop of a burst
    exp_beat(20, 1, 0);
    base = pop_total;
    for (int i = 20; i <= 25; i++) push(DW'(i));
    for (int i = 0; i < 50; i++) begin
      if (pop_total - base >= 2) break;
      @(posedge clk); #1;
    end
    chk("t6 pops before reset", 64'(pop_total - base), 64'd2);
    rstn = 1'b0;
    #1;
    chk("t6 rst out_vld", 64'(out_vld), 64'd0);
    chk("t6 rst fifo_rdy", 64'(fifo_rdy), 64'd0);
    chk("t6 rst busy", 64'(busy), 64'd0);
    chk("t6 rst burst_cnt", 64'(burst_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t6 rst out_data", 64'(out_data), 64'd0);
    chk("t6 remaining words", 64'(fq.size()), 64'd4);
    rstn = 1'b1;
    exp_beat(22, 1, 0); exp_beat(23, 0, 0); exp_beat(24, 0, 0); exp_beat(25, 0, 0); exp_beat(0, 0, 1);
    wait_idle("t6 idle", 200);
    chk("t6 burst_cnt", 64'(burst_cnt), 64'd1);

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
